// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-to-device transmitter:
//   - state encoding of the transmit FSM
//   - frame constants (data bits, fall index of the stop bit and of the ack)
//   - helper that turns a time in microseconds into a clock-cycle count
// ---------------------------------------------------------------------------
package ps2_pkg;

    // State encoding kept as plain constants so older code that compares
    // against raw 3-bit values keeps working.
    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t IDLE      = 3'd0;
    localparam ps2_state_t INHIBIT   = 3'd1;
    localparam ps2_state_t RTS       = 3'd2;
    localparam ps2_state_t SEND      = 3'd3;
    localparam ps2_state_t ACK       = 3'd4;
    localparam ps2_state_t WAIT_IDLE = 3'd5;

    // Frame layout as seen from the device clock: falls 1-8 carry data,
    // fall 9 parity, fall 10 the stop bit, fall 11 is the ack slot.
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_FALL = 10;
    localparam int unsigned ACK_FALL  = 11;

    // Integer MHz first, then scale: matches how the legacy core derived
    // its timing constants and keeps the product inside 32 bits.
    function automatic int unsigned us_to_cycles(input int unsigned clk_freq_hz,
                                                 input int unsigned us);
        return (clk_freq_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Brings one raw PS/2 line into the m_clock domain and removes short
// glitches. A new level is accepted only after FILTER_LEN consecutive
// synchronized samples agree on it.
//   m_clock  in   system clock
//   p_reset  in   asynchronous active-high reset
//   raw      in   raw line level (open-drain bus, idles high)
//   filt     out  filtered level, resets to 1 (idle bus)
// Latency from raw to filt is 2 + FILTER_LEN clock edges.
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic raw,
    output logic filt
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of statement
    // order (sync2 <= sync1 must see the old sync1).
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            run_cnt <= '0;
            filt    <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // run_cnt counts how long the synchronized level has disagreed
            // with the accepted one; any agreeing sample restarts the run.
            if (sync2 == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                filt    <= sync2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one byte (LSB first, odd parity, stop) out on device clock falls
// and checks the device acknowledge.
//   m_clock      in   system clock
//   p_reset      in   asynchronous active-high reset
//   tx_valid     in   byte request, accepted when tx_valid && tx_ready
//   tx_data      in   byte to send
//   tx_ready     out  high only in IDLE
//   busy         out  high outside IDLE; the receiver ignores the lines
//   ps2_clk_in   in   raw PS/2 clock line
//   ps2_dat_in   in   raw PS/2 data line
//   ps2_clk_oe   out  1 = pull clock line low
//   ps2_dat_oe   out  1 = pull data line low
//   done         out  one-cycle pulse at end of frame (acked or not)
//   err_noack    out  valid with done; 1 = device did not ack
//   err_timeout  out  one-cycle pulse when the frame times out (no done)
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 15000,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       err_noack,
    output logic       err_timeout
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);

    ps2_state_t       state;
    logic [7:0]       shreg;
    logic             parity_bit;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             noack_q;

    logic             clk_f;
    logic             dat_f;
    logic             clk_f_d;
    logic             fall;
    logic             to_active;
    logic             timeout_hit;
    logic             line_idle;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .raw     (ps2_clk_in),
        .filt    (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .raw     (ps2_dat_in),
        .filt    (dat_f)
    );

    assign fall        = clk_f_d & ~clk_f;
    assign line_idle   = clk_f & dat_f;
    assign to_active   = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign timeout_hit = to_active && (to_cnt == TO_W'(TIMEOUT_CYC));

    // Status outputs are decoded from state so that the done / timeout cycle
    // still shows busy and tx_ready comes back on the following cycle.
    assign tx_ready    = (state == IDLE);
    assign busy        = ~tx_ready;
    assign done        = (state == WAIT_IDLE) && line_idle && !timeout_hit;
    assign err_noack   = done & noack_q;
    assign err_timeout = timeout_hit;
    // Release both lines in the timeout cycle itself, not one cycle later.
    assign ps2_clk_oe  = clk_oe_q & ~timeout_hit;
    assign ps2_dat_oe  = dat_oe_q & ~timeout_hit;

    // NOTE: every control flop, including the line drivers, sits on the
    // asynchronous reset so a reset mid-frame frees the bus without waiting
    // for a clock; the data shift register is reset too because it is tiny.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state      <= IDLE;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            noack_q    <= 1'b0;
            clk_f_d    <= 1'b1;
        end else begin
            clk_f_d <= clk_f;

            if (timeout_hit) begin
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            shreg      <= tx_data;
                            parity_bit <= ~^tx_data;
                            noack_q    <= 1'b0;
                            inh_cnt    <= '0;
                            clk_oe_q   <= 1'b1;
                            dat_oe_q   <= 1'b0;
                            state      <= INHIBIT;
                        end
                    end

                    INHIBIT: begin
                        if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                            dat_oe_q <= 1'b1;
                            state    <= RTS;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end

                    // Data stays low: that is the start bit the device
                    // reads on its first clock.
                    RTS: begin
                        clk_oe_q <= 1'b0;
                        bit_cnt  <= '0;
                        to_cnt   <= '0;
                        state    <= SEND;
                    end

                    // bit_cnt holds the number of falls already seen.
                    SEND: begin
                        to_cnt <= to_cnt + 1'b1;
                        if (fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 4'(DATA_BITS)) begin
                                dat_oe_q <= ~shreg[0];
                                shreg    <= shreg >> 1;
                            end else if (bit_cnt == 4'(DATA_BITS)) begin
                                dat_oe_q <= ~parity_bit;
                            end else begin
                                dat_oe_q <= 1'b0;
                                state    <= ACK;
                            end
                        end
                    end

                    ACK: begin
                        to_cnt <= to_cnt + 1'b1;
                        if (fall) begin
                            noack_q <= dat_f;
                            bit_cnt <= 4'(ACK_FALL);
                            state   <= WAIT_IDLE;
                        end
                    end

                    WAIT_IDLE: begin
                        to_cnt <= to_cnt + 1'b1;
                        if (line_idle) begin
                            state <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx. Timing is scaled (2 MHz system clock) so
// that inhibit = 100 cycles and timeout = 5000 cycles; the device model
// clocks with a 160-cycle period, which is 12.5 kHz at that scale.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int INH_CYC = 100;
    localparam int TO_CYC  = 5000;
    localparam int HALF    = 80;

    logic       clk;
    logic       p_reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       done;
    logic       err_noack;
    logic       err_timeout;

    logic       dev_clk;
    logic       dev_dat;

    int checks = 0;
    int errors = 0;

    // Open-drain bus: a line is high only if neither side pulls it low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ (2_000_000),
        .INHIBIT_US  (50),
        .TIMEOUT_US  (2500),
        .FILTER_LEN  (4)
    ) dut (
        .m_clock     (clk),
        .p_reset     (p_reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .done        (done),
        .err_noack   (err_noack),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept a byte and measure how long clk_oe and clk_oe&&dat_oe stay high.
    task automatic start_frame(input logic [7:0] d, input string tag,
                               output int inh_len, output int rts_len);
        int guard;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        check({tag, "_ready_before"}, 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        check({tag, "_clk_oe_next_cycle"}, 32'(ps2_clk_oe), 32'd1);
        inh_len = 0;
        rts_len = 0;
        guard   = 0;
        while (ps2_clk_oe && guard < 10000) begin
            inh_len++;
            if (ps2_dat_oe) rts_len++;
            @(negedge clk);
            guard++;
        end
    endtask

    // Device clocks n_falls falls; seen[i] is dat_oe late in the low phase
    // of fall i+1. With n_falls < 11 the task leaves the clock low.
    task automatic device_frame(input bit ack, input bit glitch, input int n_falls,
                                output logic [9:0] seen);
        seen = '0;
        repeat (50) @(negedge clk);
        for (int f = 1; f <= n_falls; f++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (f <= 10) seen[f-1] = ps2_dat_oe;
            if (f < n_falls) begin
                dev_clk = 1'b1;
                repeat (HALF / 2) @(negedge clk);
                if (glitch && f <= 9) begin
                    dev_clk = 1'b0;
                    repeat (2) @(negedge clk);
                    dev_clk = 1'b1;
                end else begin
                    repeat (2) @(negedge clk);
                end
                if (f == 10 && ack) dev_dat = 1'b0;
                repeat (HALF - HALF / 2 - 2) @(negedge clk);
            end else if (n_falls == 11) begin
                dev_clk = 1'b1;
                dev_dat = 1'b1;
            end
        end
    endtask

    task automatic wait_done(output bit found, output logic nack, output logic rdy);
        found = 1'b0;
        nack  = 1'b0;
        rdy   = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                nack  = err_noack;
                rdy   = tx_ready;
            end
        end
    endtask

    initial begin
        int         inh_len;
        int         rts_len;
        int         n;
        bit         found;
        bit         saw_done;
        logic       nack;
        logic       rdy;
        logic [9:0] seen;

        p_reset  = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx_ready",    32'(tx_ready),    32'd1);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_clk_oe",      32'(ps2_clk_oe),  32'd0);
        check("rst_dat_oe",      32'(ps2_dat_oe),  32'd0);
        check("rst_done",        32'(done),        32'd0);
        check("rst_err_noack",   32'(err_noack),   32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        p_reset = 1'b0;
        repeat (10) @(negedge clk);

        // 0xED with ack: dat_oe 0,1,0,0,1,0,0,0 data, 0 parity, 0 stop
        start_frame(8'hED, "ed", inh_len, rts_len);
        check("ed_inhibit_len", 32'(inh_len), 32'(INH_CYC + 1));
        check("ed_rts_len",     32'(rts_len), 32'd1);
        device_frame(1'b1, 1'b0, 11, seen);
        check("ed_bits", 32'(seen), 32'h012);
        wait_done(found, nack, rdy);
        check("ed_done",           32'(found), 32'd1);
        check("ed_noack",          32'(nack),  32'd0);
        check("ed_ready_in_done",  32'(rdy),   32'd0);
        @(negedge clk);
        check("ed_ready_after",    32'(tx_ready), 32'd1);
        check("ed_done_one_cycle", 32'(done),     32'd0);

        // 0xA5 with reset asserted while fall 5 is low (bit 4 = 0 -> oe 1)
        start_frame(8'hA5, "a5", inh_len, rts_len);
        device_frame(1'b1, 1'b0, 5, seen);
        check("a5_bits_1_to_5", 32'(seen),       32'h01A);
        check("a5_dat_oe_pre",  32'(ps2_dat_oe), 32'd1);
        #2 p_reset = 1'b1;
        #1;
        check("a5_rst_clk_oe",   32'(ps2_clk_oe),  32'd0);
        check("a5_rst_dat_oe",   32'(ps2_dat_oe),  32'd0);
        check("a5_rst_tx_ready", 32'(tx_ready),    32'd1);
        check("a5_rst_done",     32'(done),        32'd0);
        check("a5_rst_timeout",  32'(err_timeout), 32'd0);
        dev_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        p_reset = 1'b0;
        repeat (10) @(negedge clk);

        // 0x01 after reset: parity level 0 -> parity oe 1
        start_frame(8'h01, "x01", inh_len, rts_len);
        check("x01_inhibit_len", 32'(inh_len), 32'(INH_CYC + 1));
        check("x01_rts_len",     32'(rts_len), 32'd1);
        device_frame(1'b1, 1'b0, 11, seen);
        check("x01_bits", 32'(seen), 32'h1FE);
        wait_done(found, nack, rdy);
        check("x01_done",  32'(found), 32'd1);
        check("x01_noack", 32'(nack),  32'd0);

        // 0xFF: parity level 1 -> every oe sample 0
        start_frame(8'hFF, "xff", inh_len, rts_len);
        check("xff_inhibit_len", 32'(inh_len), 32'(INH_CYC + 1));
        check("xff_rts_len",     32'(rts_len), 32'd1);
        device_frame(1'b1, 1'b0, 11, seen);
        check("xff_bits", 32'(seen), 32'h000);
        wait_done(found, nack, rdy);
        check("xff_done",  32'(found), 32'd1);
        check("xff_noack", 32'(nack),  32'd0);

        // 0xF4 without ack
        start_frame(8'hF4, "f4", inh_len, rts_len);
        device_frame(1'b0, 1'b0, 11, seen);
        check("f4_bits", 32'(seen), 32'h10B);
        wait_done(found, nack, rdy);
        check("f4_done",  32'(found), 32'd1);
        check("f4_noack", 32'(nack),  32'd1);
        @(negedge clk);
        check("f4_idle_ready", 32'(tx_ready), 32'd1);
        check("f4_idle_busy",  32'(busy),     32'd0);

        // 0x3C with 2-cycle clock glitches and a request while busy
        start_frame(8'h3C, "g3c", inh_len, rts_len);
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        check("g3c_ready_busy", 32'(tx_ready), 32'd0);
        @(negedge clk);
        tx_valid = 1'b0;
        device_frame(1'b1, 1'b1, 11, seen);
        check("g3c_bits", 32'(seen), 32'h0C3);
        wait_done(found, nack, rdy);
        check("g3c_done",  32'(found), 32'd1);
        check("g3c_noack", 32'(nack),  32'd0);
        repeat (30) @(negedge clk);
        check("g3c_dropped_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("g3c_dropped_ready",  32'(tx_ready),   32'd1);

        // 0x66 with a silent device: timeout TO_CYC cycles after clk release
        start_frame(8'h66, "to", inh_len, rts_len);
        n        = 0;
        saw_done = 1'b0;
        while (!err_timeout && n < TO_CYC + 1000) begin
            @(negedge clk);
            n++;
            if (done) saw_done = 1'b1;
        end
        check("to_cycles",  32'(n),           32'(TO_CYC));
        check("to_pulse",   32'(err_timeout), 32'd1);
        check("to_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("to_dat_oe",  32'(ps2_dat_oe),  32'd0);
        check("to_no_done", 32'(saw_done),    32'd0);
        @(negedge clk);
        check("to_ready_after", 32'(tx_ready),    32'd1);
        check("to_pulse_ended", 32'(err_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
